// File: rtl/wb_retire_unit.sv
// Retire stage: buffers executed instructions, commits writebacks to the 32-entry register file, reports branches.
// 1-cycle min accept-to-retire; in_ready drops when DEPTH entries are held. Optional OVERFLOW_TRAP_EN suppresses overflowing writes.
module wb_retire_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_result,
  input  logic [2:0]        in_flags,
  input  logic              wb_stall,
  input  logic [4:0]        rd_addr_a,
  input  logic [4:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              br_valid,
  output logic              br_taken,
  output logic              exc_ovf,
  output logic [31:0]       retire_count
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]       q_instr  [DEPTH];
  logic [DATA_W-1:0] q_result [DEPTH];
  logic [2:0]        q_flags  [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       occ;
  logic              push, pop;

  assign in_ready = (occ != (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (occ != '0) && !wb_stall;

  // Payload storage needs no reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      q_instr[wr_ptr]  <= in_instr;
      q_result[wr_ptr] <= in_result;
      q_flags[wr_ptr]  <= in_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  logic [31:0]       head_instr;
  logic [DATA_W-1:0] head_result;
  logic [2:0]        head_flags;
  logic [5:0]        op, fn;
  logic [4:0]        dst;
  logic              dst_en, is_slt, is_br, br_dec, trap, we;
  logic [DATA_W-1:0] wval;

  assign head_instr  = q_instr[rd_ptr];
  assign head_result = q_result[rd_ptr];
  assign head_flags  = q_flags[rd_ptr];
  assign op          = head_instr[31:26];
  assign fn          = head_instr[5:0];

  always_comb begin
    dst    = 5'd0;
    dst_en = 1'b0;
    is_slt = 1'b0;
    is_br  = 1'b0;
    br_dec = 1'b0;
    case (op)
      6'h00: begin
        if (fn != 6'h08) begin
          dst_en = 1'b1;
          dst    = head_instr[15:11];
        end
        is_slt = (fn == 6'h2A) || (fn == 6'h2B);
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
        dst_en = 1'b1;
        dst    = head_instr[20:16];
        is_slt = (op == 6'h0A) || (op == 6'h0B);
      end
      6'h04: begin
        is_br  = 1'b1;
        br_dec = head_flags[2];
      end
      6'h05: begin
        is_br  = 1'b1;
        br_dec = !head_flags[2];
      end
      default: ;
    endcase
  end

`ifdef OVERFLOW_TRAP_EN
  assign trap = head_flags[0] &&
                (((op == 6'h00) && ((fn == 6'h20) || (fn == 6'h22))) || (op == 6'h08));
  logic unused_bits;
  assign unused_bits = ^{head_instr[25:21], head_instr[10:6]};
`else
  assign trap = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{head_instr[25:21], head_instr[10:6], head_flags[0]};
`endif

  assign wval = is_slt ? {{(DATA_W-1){1'b0}}, head_flags[1]} : head_result;
  assign we   = pop && dst_en && (dst != 5'd0) && !trap;

  logic [DATA_W-1:0] regs [32];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we) begin
      regs[dst] <= wval;
    end
  end

  // Bypass lets EX read a value in the same cycle it is committed.
  always_comb begin
    rd_data_a = '0;
    rd_data_b = '0;
    if (rd_addr_a != 5'd0) rd_data_a = (we && rd_addr_a == dst) ? wval : regs[rd_addr_a];
    if (rd_addr_b != 5'd0) rd_data_b = (we && rd_addr_b == dst) ? wval : regs[rd_addr_b];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_valid     <= 1'b0;
      br_taken     <= 1'b0;
      retire_count <= '0;
    end else begin
      br_valid <= pop && is_br;
      br_taken <= pop && is_br && br_dec;
      if (pop) retire_count <= retire_count + 1'b1;
    end
  end

`ifdef OVERFLOW_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) exc_ovf <= 1'b0;
    else        exc_ovf <= pop && trap;
  end
`else
  assign exc_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_wb_retire_unit.sv
// Directed bench for wb_retire_unit with DEPTH=2; checks commit values, bypass, branches, stall fill and reset.
module tb_wb_retire_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_result;
  logic [2:0]  in_flags;
  logic        wb_stall;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        br_valid, br_taken, exc_ovf;
  logic [31:0] retire_count;

  int tests = 0;
  int fails = 0;

  wb_retire_unit #(.DATA_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_result(in_result), .in_flags(in_flags),
    .wb_stall(wb_stall),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .br_valid(br_valid), .br_taken(br_taken), .exc_ovf(exc_ovf),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] res, input logic [2:0] fl);
    in_valid  = 1'b1;
    in_instr  = instr;
    in_result = res;
    in_flags  = fl;
    step();
    in_valid  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_result = '0; in_flags = '0;
    wb_stall = 1'b0; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    #12 rst_n = 1'b1;
    step();

    rd_addr_a = 5'd5;
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_count", retire_count, 32'd0);
    check("reset_br_valid", {31'b0, br_valid}, 32'd0);
    check("reset_exc_ovf", {31'b0, exc_ovf}, 32'd0);
    check("reset_r5", rd_data_a, 32'd0);

    // ADDIU r5 = 7: bypass while retiring, then array
    push(32'h24050007, 32'd7, 3'b000);
    check("addiu_bypass", rd_data_a, 32'd7);
    step();
    check("addiu_r5", rd_data_a, 32'd7);
    check("addiu_count", retire_count, 32'd1);

    // SLT r3 takes the negative flag, not the result
    rd_addr_a = 5'd3;
    push(32'h0022182A, 32'hFFFFFFFE, 3'b010);
    step();
    check("slt_set", rd_data_a, 32'd1);
    push(32'h0022182A, 32'hFFFFFFFE, 3'b000);
    step();
    check("slt_clear", rd_data_a, 32'd0);
    check("slt_count", retire_count, 32'd3);

    // Branches
    rd_addr_a = 5'd5;
    push(32'h10220003, 32'd0, 3'b100);
    step();
    check("beq_valid", {31'b0, br_valid}, 32'd1);
    check("beq_taken", {31'b0, br_taken}, 32'd1);
    check("beq_no_write_r5", rd_data_a, 32'd7);
    push(32'h14220003, 32'd0, 3'b100);
    check("br_pulse_drop", {31'b0, br_valid}, 32'd0);
    step();
    check("bne_valid", {31'b0, br_valid}, 32'd1);
    check("bne_taken", {31'b0, br_taken}, 32'd0);
    step();
    check("bne_pulse_end", {31'b0, br_valid}, 32'd0);
    check("br_count", retire_count, 32'd5);

    // Stall fills the buffer; release retires in order
    wb_stall = 1'b1;
    rd_addr_a = 5'd6; rd_addr_b = 5'd8;
    in_valid = 1'b1; in_instr = 32'h24060011; in_result = 32'h11; in_flags = 3'b000;
    step();
    check("stall_ready_1", {31'b0, in_ready}, 32'd1);
    in_instr = 32'h24070022; in_result = 32'h22;
    step();
    check("stall_full", {31'b0, in_ready}, 32'd0);
    in_instr = 32'h24080033; in_result = 32'h33;
    step();
    check("stall_hold", {31'b0, in_ready}, 32'd0);
    check("stall_count", retire_count, 32'd5);
    wb_stall = 1'b0;
    step();
    check("rel1_count", retire_count, 32'd6);
    check("rel1_r6", rd_data_a, 32'h11);
    check("rel1_r8", rd_data_b, 32'd0);
    step();
    in_valid = 1'b0;
    check("rel2_count", retire_count, 32'd7);
    step();
    check("rel3_count", retire_count, 32'd8);
    check("rel3_r8", rd_data_b, 32'h33);
    rd_addr_a = 5'd7;
    #1;
    check("rel3_r7", rd_data_a, 32'h22);

    // ADD overflow
    rd_addr_a = 5'd4;
    push(32'h00222020, 32'h80000000, 3'b001);
    step();
`ifdef OVERFLOW_TRAP_EN
    check("ovf_r4", rd_data_a, 32'd0);
    check("ovf_exc", {31'b0, exc_ovf}, 32'd1);
`else
    check("ovf_r4", rd_data_a, 32'h80000000);
    check("ovf_exc", {31'b0, exc_ovf}, 32'd0);
`endif
    check("ovf_count", retire_count, 32'd9);
    step();
    check("ovf_exc_end", {31'b0, exc_ovf}, 32'd0);

    // ADDU to r0 is discarded
    rd_addr_a = 5'd0;
    push(32'h00220021, 32'h1234, 3'b000);
    check("r0_bypass", rd_data_a, 32'd0);
    step();
    check("r0_read", rd_data_a, 32'd0);
    check("r0_count", retire_count, 32'd10);

    // Reset with two buffered entries
    wb_stall = 1'b1;
    push(32'h24090099, 32'h99, 3'b000);
    push(32'h240A00AA, 32'hAA, 3'b000);
    check("pre_rst_full", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #3;
    check("rst_count", retire_count, 32'd0);
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    rst_n = 1'b1;
    wb_stall = 1'b0;
    rd_addr_a = 5'd9; rd_addr_b = 5'd5;
    step();
    step();
    check("rst_r9_dropped", rd_data_a, 32'd0);
    check("rst_r5_cleared", rd_data_b, 32'd0);
    check("rst_count_after", retire_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
